// File: rtl/cache_ctrl_fsm_if.sv
// CPU request, tag/way array and line-memory signals of the cache sequencing controller.
// The master side is the controller; the slave side is the array/memory/CPU environment.
interface cache_ctrl_fsm_if;
  localparam int unsigned TAG_W   = 19;
  localparam int unsigned INDEX_W = 7;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned WAYS    = 4;

  logic               cpu_req;
  logic               cpu_we;
  logic [ADDR_W-1:0]  cpu_addr;
  logic               cpu_ready;
  logic [INDEX_W-1:0] set_idx;
  logic [TAG_W-1:0]   lookup_tag;
  logic [WAYS-1:0]    hit_way;
  logic [WAYS-1:0]    valid_way;
  logic [WAYS-1:0]    dirty_way;
  logic [TAG_W-1:0]   vic_tag;
  logic [WAYS-1:0]    way_sel;
  logic [1:0]         line_sel;
  logic               word_we;
  logic               set_dirty;
  logic               fill_we;
  logic               mem_rd_req;
  logic               mem_wr_req;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_ack;

  modport master (
    input  cpu_req, cpu_we, cpu_addr, hit_way, valid_way, dirty_way, vic_tag, mem_ack,
    output cpu_ready, set_idx, lookup_tag, way_sel, line_sel, word_we, set_dirty,
           fill_we, mem_rd_req, mem_wr_req, mem_addr
  );

  modport slave (
    output cpu_req, cpu_we, cpu_addr, hit_way, valid_way, dirty_way, vic_tag, mem_ack,
    input  cpu_ready, set_idx, lookup_tag, way_sel, line_sel, word_we, set_dirty,
           fill_we, mem_rd_req, mem_wr_req, mem_addr
  );
endinterface

// File: rtl/cache_ctrl_fsm.sv
// Sequencing controller for a 4-way set-associative cache: lookup, dirty-victim
// writeback, line refill and per-set tree pseudo-LRU replacement.
module cache_ctrl_fsm (
  input  logic             clk,
  input  logic             rst_n,
  cache_ctrl_fsm_if.master bus
);
  localparam int unsigned TAG_W    = 19;
  localparam int unsigned INDEX_W  = 7;
  localparam int unsigned OFFSET_W = 6;
  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned WAYS     = 4;
  localparam int unsigned SETS     = 1 << INDEX_W;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOOKUP    = 3'd1,
    WRITEBACK = 3'd2,
    REFILL    = 3'd3,
    RESPOND   = 3'd4
  } state_t;

  state_t                   state_q;
  logic                     we_q;
  logic [1:0]               line_sel_q;
  logic [SETS-1:0][2:0]     plru_q;
  logic                     cpu_ready_q;
  logic                     word_we_q;
  logic                     set_dirty_q;
  logic                     mem_rd_q;
  logic                     mem_wr_q;
  logic [WAYS-1:0]          way_sel_q;
  logic [INDEX_W-1:0]       set_idx_q;
  logic [TAG_W-1:0]         tag_q;
  logic [ADDR_W-1:0]        mem_addr_q;

  logic                     hit_any_c;
  logic [1:0]               hit_idx_c;
  logic [1:0]               victim_c;
  logic                     vic_dirty_c;
  logic [2:0]               plru_set_c;
  logic                     unused_offset;

  assign unused_offset = ^bus.cpu_addr[OFFSET_W-1:0];

  // Tree PLRU update after an access to way w: point both levels away from w.
  function automatic logic [2:0] plru_touch(input logic [2:0] p, input logic [1:0] w);
    logic [2:0] n;
    n    = p;
    n[0] = ~w[1];
    if (w[1]) n[2] = ~w[0];
    else      n[1] = ~w[0];
    return n;
  endfunction

  function automatic logic [WAYS-1:0] onehot(input logic [1:0] w);
    return WAYS'(1) << w;
  endfunction

  function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0] t,
                                                  input logic [INDEX_W-1:0] i);
    return {t, i, OFFSET_W'(0)};
  endfunction

  // Hit way (lowest index wins) and victim (lowest invalid way, else PLRU).
  always_comb begin
    hit_any_c  = |bus.hit_way;
    hit_idx_c  = 2'd0;
    for (int i = int'(WAYS) - 1; i >= 0; i--) begin
      if (bus.hit_way[i]) hit_idx_c = 2'(i);
    end
    plru_set_c = plru_q[set_idx_q];
    victim_c   = plru_set_c[0] ? {1'b1, plru_set_c[2]} : {1'b0, plru_set_c[1]};
    for (int i = int'(WAYS) - 1; i >= 0; i--) begin
      if (!bus.valid_way[i]) victim_c = 2'(i);
    end
    vic_dirty_c = bus.valid_way[victim_c] & bus.dirty_way[victim_c];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      line_sel_q  <= '0;
      plru_q      <= '0;
      cpu_ready_q <= 1'b0;
      word_we_q   <= 1'b0;
      set_dirty_q <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      way_sel_q   <= '0;
      set_idx_q   <= '0;
      tag_q       <= '0;
      mem_addr_q  <= '0;
    end else begin
      cpu_ready_q <= 1'b0;
      word_we_q   <= 1'b0;
      set_dirty_q <= 1'b0;
      way_sel_q   <= '0;
      case (state_q)
        IDLE: begin
          if (bus.cpu_req) begin
            set_idx_q <= bus.cpu_addr[OFFSET_W +: INDEX_W];
            tag_q     <= bus.cpu_addr[ADDR_W-1 -: TAG_W];
            we_q      <= bus.cpu_we;
            state_q   <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit_any_c) begin
            plru_q[set_idx_q] <= plru_touch(plru_set_c, hit_idx_c);
            way_sel_q         <= onehot(hit_idx_c);
            cpu_ready_q       <= 1'b1;
            word_we_q         <= we_q;
            set_dirty_q       <= we_q;
            state_q           <= RESPOND;
          end else begin
            line_sel_q <= victim_c;
            if (vic_dirty_c) begin
              mem_wr_q   <= 1'b1;
              mem_addr_q <= line_addr(bus.vic_tag, set_idx_q);
              state_q    <= WRITEBACK;
            end else begin
              mem_rd_q   <= 1'b1;
              mem_addr_q <= line_addr(tag_q, set_idx_q);
              state_q    <= REFILL;
            end
          end
        end
        WRITEBACK: begin
          if (bus.mem_ack) begin
            mem_wr_q   <= 1'b0;
            mem_rd_q   <= 1'b1;
            mem_addr_q <= line_addr(tag_q, set_idx_q);
            state_q    <= REFILL;
          end
        end
        REFILL: begin
          if (bus.mem_ack) begin
            mem_rd_q          <= 1'b0;
            mem_addr_q        <= '0;
            plru_q[set_idx_q] <= plru_touch(plru_set_c, line_sel_q);
            way_sel_q         <= onehot(line_sel_q);
            cpu_ready_q       <= 1'b1;
            word_we_q         <= we_q;
            set_dirty_q       <= we_q;
            state_q           <= RESPOND;
          end
        end
        RESPOND: begin
          line_sel_q <= '0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // The victim is steered onto line_sel during LOOKUP so vic_tag is valid for the writeback address.
  assign bus.line_sel   = (state_q == LOOKUP) ? victim_c : line_sel_q;
  assign bus.fill_we    = (state_q == REFILL) & bus.mem_ack;
  assign bus.cpu_ready  = cpu_ready_q;
  assign bus.set_idx    = set_idx_q;
  assign bus.lookup_tag = tag_q;
  assign bus.way_sel    = way_sel_q;
  assign bus.word_we    = word_we_q;
  assign bus.set_dirty  = set_dirty_q;
  assign bus.mem_rd_req = mem_rd_q;
  assign bus.mem_wr_req = mem_wr_q;
  assign bus.mem_addr   = mem_addr_q;
endmodule
